mp_rsf_pipe: RTL and testbench
==============================

Name: mp_rsf_pipe

Overview:
Pipelined dynamic right shifter, c = a >> b, with valid/ready handshake on input and output.
- Inverse direction of the combinational dynamic left shifter: the left shifter aligns operands upward; this block scales accumulated results back down (requantization after a mixed-precision MAC array).
- Logarithmic structure: one registered stage per shift-amount bit, full throughput of one result per cycle, stalls under backpressure.

Parameters:
N, 16, data width of a and c
S, 4, shift-amount width; stage i shifts by 2**i
ARITH, 1, 1 = arithmetic shift (sign fill), 0 = logical shift (zero fill)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept an operand this cycle
in_a  input  N  value to shift
in_b  input  S  right-shift amount, unsigned
out_valid  output  1  out_c valid
out_ready  input  1  downstream accepts out_c
out_c  output  N  shifted result

Behaviour:
- Reset: rst high at a clock edge clears all stage valid bits. Next cycle: out_valid=0, in_ready=1, out_c=0. Data registers are also cleared to 0.
- Pipeline: S register stages.
  - Stage i takes the value from stage i-1 (stage 0 takes in_a) and shifts it right by 2**i if bit i of the carried shift amount is 1; otherwise it passes the value unchanged.
  - Fill bit is the MSB of the original in_a when ARITH=1, and 0 when ARITH=0.
  - Each stage carries the unused high bits of b forward.
- Latency: S cycles from input accept to out_valid, when there is no stall.
- Advance enable: en = ~out_valid | out_ready. This is a single global enable for all stages.
  - When en=1, all stages advance.
  - When en=0, all stage registers hold.
- in_ready = en. This is combinational from out_ready and out_valid.
- Input transfer occurs when in_valid & in_ready. The stage-0 valid bit loads in_valid whenever en=1, so bubbles propagate.
- Output transfer occurs when out_valid & out_ready. A new result may appear in the same cycle as a transfer, giving back-to-back throughput of 1 per cycle.
- While out_valid=1 and out_ready=0, out_c is held stable.
- Shift amount 0 passes the value through unchanged.
- A shift amount of N or more yields all fill bits. This can only occur when 2**S-1 >= N.
- Reset mid-operation drops every in-flight operand; no partial output is produced.
- No data dependency between operands; results are delivered in order.

Optional Feature:
Macro MP_RSF_ROUND_EN.
- Defined:
  - Each active stage captures the most significant bit it shifts out into a per-operand round bit. Inactive stages keep the round bit.
  - An extra output register stage adds the round bit to the result (round half up), so latency is S+1.
  - Shift 0 gives round bit 0.
  - No overflow is possible: for any shift of 1 or more, the pre-round result is at most 2**(N-2)-1 (ARITH=1) or 2**(N-1)-1 (ARITH=0).
  - The extra stage participates in the same global enable.
- Undefined: truncation toward negative infinity (ARITH=1) or toward zero (ARITH=0), latency S.

Decomposition:
- Shared package mp_pkg:
  - localparam function for stage count (S, or S+1 with rounding)
  - typedef of the stage payload struct {data N, shamt S, round 1, valid 1}
- Sub-module mp_rsf_stage: one registered shift-by-constant stage.
  - Parameters: N, S, index I.
  - Ports: clk, rst, en, payload in/out.
  - The top level instantiates it S times in a generate loop.

Test Plan:
- ARITH=1: in_a=0x8000, in_b=4 -> out_c=0xF800 after 4 cycles. ARITH=0, same inputs -> 0x0800.
- in_a=0x00FF, in_b=3 -> 0x001F. With MP_RSF_ROUND_EN -> 0x0020 after 5 cycles. ARITH=1, in_a=0xFFFF, in_b=15, rounding -> 0x0000; no rounding -> 0xFFFF.
- Boundaries: in_b=0, in_a=0x1234 -> 0x1234 with no round increment. ARITH=1, in_a=0x7FFF, in_b=15 -> 0x0000.
- Throughput: 8 back-to-back operands with out_ready=1 -> 8 consecutive out_valid cycles, results in order, in_ready constantly 1.
- Backpressure: 5 operands pushed while out_ready is held 0 -> in_ready drops once the pipeline is full and out_c stays stable. Release out_ready -> all 5 results delivered in order, none lost or duplicated.
- Reset mid-stream: rst asserted 1 cycle with 3 operands in flight -> next cycle out_valid=0 and out_c=0. Those operands never emerge; an operand sent after reset returns with normal latency.

Source files
------------

// File: rtl/mp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mp_pkg : shared types for the mp_rsf_pipe right-shift pipeline.            |
// | Optional rounding macro: MP_RSF_ROUND_EN.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mp_pkg;

  localparam int unsigned MP_N = 16;
  localparam int unsigned MP_S = 4;

  // Register stages between input accept and out_valid.
  function automatic int unsigned mp_stage_count(input int unsigned s);
`ifdef MP_RSF_ROUND_EN
    return s + 1;
`else
    return s;
`endif
  endfunction

  typedef struct packed {
    logic [MP_N-1:0] data;
    logic [MP_S-1:0] shamt;
    logic            round;
    logic            valid;
  } mp_payload_t;

endpackage
`default_nettype wire

// File: rtl/mp_rsf_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mp_rsf_stage : one registered stage, conditional right shift by 2**I.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mp_rsf_stage
  import mp_pkg::*;
#(
  parameter int unsigned N     = MP_N,
  parameter int unsigned S     = MP_S,
  parameter int unsigned I     = 0,
  parameter bit          ARITH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  mp_payload_t payload_i,
  output mp_payload_t payload_o
);

  localparam int unsigned SH = 1 << I;

  logic        w_fill;
  logic        w_out_bit;
  logic [N-1:0] w_shifted;
  mp_payload_t payload_d;
  mp_payload_t payload_q;

  // An arithmetic shift never alters the MSB, so it still holds the original sign.
  assign w_fill    = ARITH ? payload_i.data[N-1] : 1'b0;
  assign w_shifted = (payload_i.data >> SH) | ({N{w_fill}} & ~({N{1'b1}} >> SH));

  if (SH >= N) begin : g_wide
    assign w_out_bit = w_fill;
  end else begin : g_narrow
    assign w_out_bit = payload_i.data[SH-1];
  end

  always_comb begin
    payload_d = payload_i;
    if (payload_i.shamt[I]) begin
      payload_d.data  = w_shifted;
      payload_d.round = w_out_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= '0;
    end else if (en) begin
      payload_q <= payload_d;
    end
  end

  assign payload_o = payload_q;

endmodule
`default_nettype wire

// File: rtl/mp_rsf_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mp_rsf_pipe : pipelined dynamic right shifter c = a >> b, valid/ready.     |
// | Optional macro MP_RSF_ROUND_EN adds a round-half-up output stage.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mp_rsf_pipe
  import mp_pkg::*;
#(
  parameter int unsigned N     = MP_N,
  parameter int unsigned S     = MP_S,
  parameter bit          ARITH = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [S-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c
);

  logic        w_en;
  mp_payload_t w_stage [0:S];

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  assign w_stage[0] = '{data: in_a, shamt: in_b, round: 1'b0, valid: in_valid};

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    mp_rsf_stage #(
      .N     (N),
      .S     (S),
      .I     (gi),
      .ARITH (ARITH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (w_en),
      .payload_i (w_stage[gi]),
      .payload_o (w_stage[gi+1])
    );
  end

`ifdef MP_RSF_ROUND_EN
  logic [N-1:0] out_c_d;
  logic [N-1:0] out_c_q;
  logic         out_valid_q;
  logic         unused_bits;

  // Cannot overflow: any nonzero shift leaves headroom for the +1.
  assign out_c_d = w_stage[S].data + {{(N-1){1'b0}}, w_stage[S].round};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (w_en) begin
      out_c_q     <= out_c_d;
      out_valid_q <= w_stage[S].valid;
    end
  end

  assign out_c       = out_c_q;
  assign out_valid   = out_valid_q;
  assign unused_bits = ^w_stage[S].shamt;
`else
  logic unused_bits;

  assign out_c       = w_stage[S].data;
  assign out_valid   = w_stage[S].valid;
  assign unused_bits = ^{w_stage[S].shamt, w_stage[S].round};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_rsf_pipe.sv
`timescale 1ns/1ps
// tb_mp_rsf_pipe : scoreboard bench driving an arithmetic and a logical
// instance of mp_rsf_pipe with identical stimulus.
module tb_mp_rsf_pipe;

  localparam int N = 16;
  localparam int S = 4;
`ifdef MP_RSF_ROUND_EN
  localparam int LAT = S + 1;
`else
  localparam int LAT = S;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] in_a;
  logic [S-1:0] in_b;
  logic         out_ready;
  logic         in_ready_a, in_ready_l;
  logic         out_valid_a, out_valid_l;
  logic [N-1:0] out_c_a, out_c_l;

  int n_checks = 0;
  int n_fail   = 0;
  int run_len  = 0;
  int max_run  = 0;
  bit rand_bp  = 1'b0;

  logic [N-1:0] exp_q [2][$];

  always #5 clk = ~clk;

  mp_rsf_pipe #(.N(N), .S(S), .ARITH(1'b1)) u_arith (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_c(out_c_a)
  );

  mp_rsf_pipe #(.N(N), .S(S), .ARITH(1'b0)) u_logic (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_c(out_c_l)
  );

  // Reference: floor(a / 2**b), or floor(a / 2**b + 1/2) when rounding.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] a, input int b, input bit arith);
    longint v;
    longint r;
    v = arith ? longint'($signed(a)) : longint'(a);
    if (b == 0) begin
      r = v;
    end else begin
`ifdef MP_RSF_ROUND_EN
      r = (v + (longint'(1) << (b - 1))) >>> b;
`else
      r = v >>> b;
`endif
    end
    return r[N-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        logic         v;
        logic [N-1:0] c;
        v = (k == 0) ? out_valid_a : out_valid_l;
        c = (k == 0) ? out_c_a : out_c_l;
        if (v) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_out dut%0d: got 0x%0h, required no output", k, c);
          end else begin
            check($sformatf("out_c dut%0d", k), longint'(c), longint'(exp_q[k][0]));
            if (out_ready) void'(exp_q[k].pop_front());
          end
        end
      end
      if (out_valid_a && out_ready) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [N-1:0] a, input logic [S-1:0] b, output int waited);
    logic acc;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    forever begin
      @(negedge clk);
      acc = in_ready_a;
      if (acc) begin
        exp_q[0].push_back(ref_shift(a, int'(b), 1'b1));
        exp_q[1].push_back(ref_shift(a, int'(b), 1'b0));
      end
      step();
      if (acc) break;
      waited++;
      if (waited > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required accept", waited);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 400) begin
      step();
      t++;
    end
    check("drain_pending", exp_q[0].size() + exp_q[1].size(), 0);
  endtask

  task automatic check_latency();
    int  lat = 0;
    bit  got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = out_valid_a;
    end
    check("latency", lat, LAT);
    step();
  endtask

  initial begin
    logic [N-1:0] va [5];
    logic [S-1:0] vb [5];
    int w;
    int nfirst;

    va = '{16'h8000, 16'h00FF, 16'hFFFF, 16'h1234, 16'h7FFF};
    vb = '{4'd4,     4'd3,     4'd15,    4'd0,     4'd15};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid_a", out_valid_a, 0);
    check("rst_out_valid_l", out_valid_l, 0);
    check("rst_in_ready",    in_ready_a,  1);
    check("rst_out_c_a",     out_c_a,     0);
    check("rst_out_c_l",     out_c_l,     0);

    // Directed vectors, each sent into an empty pipe to measure latency.
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], w);
      check_latency();
      drain();
    end

    // Throughput: 8 operands back to back.
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      send(N'($urandom), S'($urandom), w);
      check("tput_in_ready_wait", w, 0);
    end
    drain();
    check("tput_run", max_run, 8);

    // Backpressure: fill the pipe with out_ready low, then release.
    out_ready = 1'b0;
    nfirst = (LAT < 5) ? LAT : 5;
    for (int i = 0; i < nfirst; i++) send(N'($urandom), S'($urandom), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready_a, 0);
      step();
    end
    out_ready = 1'b1;
    for (int i = nfirst; i < 5; i++) send(N'($urandom), S'($urandom), w);
    drain();

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) send(N'($urandom), S'($urandom), w);
    rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid_a", out_valid_a, 0);
    check("mid_rst_out_valid_l", out_valid_l, 0);
    check("mid_rst_out_c_a",     out_c_a,     0);
    check("mid_rst_out_c_l",     out_c_l,     0);
    repeat (10) step();
    send(16'hC3A5, 4'd5, w);
    check_latency();
    drain();

    // Random traffic with random gaps and random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) send(N'($urandom), S'($urandom_range(0, 15)), w);
      else step();
    end
    drain();
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
